rcu_ctrl: RTL and testbench

- Receiver control unit for the UART receive path.
- Sequences the bit timer (enable_timer / shift_enable / packet_done), the stop-bit checker and the RX data buffer load.
- Validates the start bit at its first sample point, enforces a packet watchdog, and keeps a saturating error count for status reporting.
- Sits between the start-bit edge detector and the timer / stop-bit-checker / buffer datapath.

---
 rtl/rcu_ctrl.sv | 126 ++++++++++++
 tb/tb_rcu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_ctrl.sv
// ---------------------------------------------------------------------------
// rcu_ctrl : UART receive control FSM (bit timer, stop-bit checker, buffer load)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcu_ctrl #(
  parameter int TIMEOUT_CYC = 128,
  parameter int ERR_W       = 8,
  parameter int START_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_bit_detected,
  input  logic             serial_in_sync,
  input  logic             shift_enable,
  input  logic             packet_done,
  input  logic             framing_error,
  output logic             enable_timer,
  output logic             sbc_clear,
  output logic             sbc_enable,
  output logic             load_buffer,
  output logic             rx_busy,
  output logic             false_start,
  output logic [ERR_W-1:0] err_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RECEIVE = 3'd2,
    S_STOP    = 3'd3,
    S_CHECK   = 3'd4,
    S_LOAD    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             sampled_q, sampled_d;
  logic             false_start_q, false_start_d;
  logic [ERR_W-1:0] err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      sampled_q     <= 1'b0;
      false_start_q <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      sampled_q     <= sampled_d;
      false_start_q <= false_start_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wd_d          = '0;
    sampled_d     = 1'b0;
    false_start_d = 1'b0;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_bit_detected) state_d = S_START;
      end
      S_START: begin
        state_d = S_RECEIVE;
      end
      S_RECEIVE: begin
        wd_d      = wd_q + 1'b1;
        sampled_d = sampled_q | shift_enable;
        // Only the very first sample point is used to validate the start bit.
        if ((START_CHECK != 0) && shift_enable && !sampled_q && serial_in_sync) begin
          false_start_d = 1'b1;
          state_d       = S_IDLE;
        end else if (packet_done) begin
          state_d = S_STOP;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
        end
      end
      S_STOP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = framing_error ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog and first-sample flag live only while in RECEIVE.
    if (state_d != S_RECEIVE) begin
      wd_d      = '0;
      sampled_d = 1'b0;
    end
  end

  assign enable_timer = (state_q == S_RECEIVE);
  assign sbc_clear    = (state_q == S_START);
  assign sbc_enable   = (state_q == S_STOP);
  assign load_buffer  = (state_q == S_LOAD);
  assign rx_busy      = (state_q != S_IDLE);
  assign false_start  = false_start_q;
  assign err_count    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rcu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rcu_ctrl : scoreboard bench for rcu_ctrl (START_CHECK=1 and =0 instances)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rcu_ctrl;

  localparam int TIMEOUT = 128;
  localparam int K_GOOD = 0, K_FERR = 1, K_FALSE = 2, K_TMO = 3, K_RST = 4;
  localparam int E_BON = 0, E_CLR = 1, E_TON = 2, E_TOFF = 3, E_ENA = 4,
                 E_LOAD = 5, E_FS = 6, E_ERR = 7, E_BOFF = 8;

  typedef struct {
    int     code;
    longint cyc;
    int     err;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start_bit_detected, serial_in_sync, shift_enable, packet_done, framing_error;
  logic et0, clr0, ena0, ld0, busy0, fs0;
  logic et1, clr1, ena1, ld1, busy1, fs1;
  logic [7:0] err0, err1;

  rcu_ctrl #(.TIMEOUT_CYC(TIMEOUT), .ERR_W(8), .START_CHECK(1)) u_dut (
    .clk(clk), .rst(rst), .start_bit_detected(start_bit_detected),
    .serial_in_sync(serial_in_sync), .shift_enable(shift_enable),
    .packet_done(packet_done), .framing_error(framing_error),
    .enable_timer(et0), .sbc_clear(clr0), .sbc_enable(ena0),
    .load_buffer(ld0), .rx_busy(busy0), .false_start(fs0), .err_count(err0)
  );

  rcu_ctrl #(.TIMEOUT_CYC(TIMEOUT), .ERR_W(8), .START_CHECK(0)) u_nochk (
    .clk(clk), .rst(rst), .start_bit_detected(start_bit_detected),
    .serial_in_sync(serial_in_sync), .shift_enable(shift_enable),
    .packet_done(packet_done), .framing_error(framing_error),
    .enable_timer(et1), .sbc_clear(clr1), .sbc_enable(ena1),
    .load_buffer(ld1), .rx_busy(busy1), .false_start(fs1), .err_count(err1)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  tests = 0;
  int  fails = 0;
  ev_t q0[$];
  ev_t q1[$];
  int  merr[2];
  int  prev_et[2], prev_busy[2], prev_err[2];
  bit  mon_en = 1'b0;

  function automatic string ename(input int c);
    case (c)
      E_BON:   return "busy_rise";
      E_CLR:   return "sbc_clear";
      E_TON:   return "timer_on";
      E_TOFF:  return "timer_off";
      E_ENA:   return "sbc_enable";
      E_LOAD:  return "load_buffer";
      E_FS:    return "false_start";
      E_ERR:   return "err_change";
      E_BOFF:  return "busy_fall";
      default: return "unknown";
    endcase
  endfunction

  function automatic void push(input int u, input int code, input longint at, input int err);
    ev_t e;
    e.code = code;
    e.cyc  = at;
    e.err  = err;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic cmp(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_dut"},   longint'({et0, clr0, ena0, ld0, busy0, fs0, err0}), 0);
    cmp({tag, "_nochk"}, longint'({et1, clr1, ena1, ld1, busy1, fs1, err1}), 0);
  endtask

  task automatic check_ev(input int u, input int code, input int err);
    ev_t e;
    tests++;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL u%0d unexpected event: got %s@%0d err=%0d, required none",
               u, ename(code), cyc, err);
    end else begin
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      if (e.code != code || e.cyc != cyc || e.err != err) begin
        fails++;
        $display("FAIL u%0d event: got %s@%0d err=%0d, required %s@%0d err=%0d",
                 u, ename(code), cyc, err, ename(e.code), e.cyc, e.err);
      end
    end
  endtask

  task automatic observe(input int u, input logic et, input logic busy, input logic clr,
                         input logic ena, input logic ld, input logic fs, input int err);
    if (busy && prev_busy[u] == 0)  check_ev(u, E_BON, err);
    if (clr)                        check_ev(u, E_CLR, err);
    if (et && prev_et[u] == 0)      check_ev(u, E_TON, err);
    if (!et && prev_et[u] != 0)     check_ev(u, E_TOFF, err);
    if (ena)                        check_ev(u, E_ENA, err);
    if (ld)                         check_ev(u, E_LOAD, err);
    if (fs)                         check_ev(u, E_FS, err);
    if (err != prev_err[u])         check_ev(u, E_ERR, err);
    if (!busy && prev_busy[u] != 0) check_ev(u, E_BOFF, err);
    prev_et[u]   = int'(et);
    prev_busy[u] = int'(busy);
    prev_err[u]  = err;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      observe(0, et0, busy0, clr0, ena0, ld0, fs0, int'(err0));
      observe(1, et1, busy1, clr1, ena1, ld1, fs1, int'(err1));
    end
  end

  // Expected timeline relative to the cycle in which the start pulse is driven:
  // START at +1, RECEIVE cycle n at +(n+1); packet_done at RECEIVE cycle d.
  task automatic plan(input int u, input int kind, input longint c, input int d,
                      input int r, output int boff);
    int k;
    int nv;
    k = (u == 1 && kind == K_FALSE) ? K_GOOD : kind;
    push(u, E_BON, c + 1, merr[u]);
    push(u, E_CLR, c + 1, merr[u]);
    push(u, E_TON, c + 2, merr[u]);
    boff = 0;
    case (k)
      K_GOOD: begin
        push(u, E_TOFF, c + d + 2, merr[u]);
        push(u, E_ENA,  c + d + 2, merr[u]);
        push(u, E_LOAD, c + d + 4, merr[u]);
        push(u, E_BOFF, c + d + 5, merr[u]);
        boff = d + 5;
      end
      K_FERR: begin
        push(u, E_TOFF, c + d + 2, merr[u]);
        push(u, E_ENA,  c + d + 2, merr[u]);
        nv = (merr[u] >= 255) ? 255 : merr[u] + 1;
        if (nv != merr[u]) begin
          merr[u] = nv;
          push(u, E_ERR, c + d + 5, merr[u]);
        end
        push(u, E_BOFF, c + d + 5, merr[u]);
        boff = d + 5;
      end
      K_FALSE: begin
        push(u, E_TOFF, c + 5, merr[u]);
        push(u, E_FS,   c + 5, merr[u]);
        push(u, E_BOFF, c + 5, merr[u]);
        boff = 5;
      end
      K_TMO: begin
        push(u, E_TOFF, c + TIMEOUT + 2, merr[u]);
        nv = (merr[u] >= 255) ? 255 : merr[u] + 1;
        if (nv != merr[u]) begin
          merr[u] = nv;
          push(u, E_ERR, c + TIMEOUT + 3, merr[u]);
        end
        push(u, E_BOFF, c + TIMEOUT + 3, merr[u]);
        boff = TIMEOUT + 3;
      end
      default: begin
        nv = merr[u];
        merr[u] = 0;
        push(u, E_TOFF, c + r + 1, 0);
        if (nv != 0) push(u, E_ERR, c + r + 1, 0);
        push(u, E_BOFF, c + r + 1, 0);
        boff = r + 1;
      end
    endcase
  endtask

  task automatic run_packet(input int kind, input int d, input int r, input bit spur);
    longint c;
    int b0, b1, bmin, len, rr, rlast;
    @(negedge clk);
    c = cyc;
    plan(0, kind, c, d, r, b0);
    plan(1, kind, c, d, r, b1);
    bmin  = (b0 < b1) ? b0 : b1;
    len   = ((b0 > b1) ? b0 : b1) + 1 + int'($urandom_range(0, 2));
    rlast = (kind == K_TMO) ? TIMEOUT : d;
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk);
      rr = t - 1;
      start_bit_detected = (t == 0) || (spur && t < bmin && $urandom_range(0, 5) == 0);
      shift_enable   = (rr >= 1 && rr <= rlast) &&
                       (rr == 3 || (rr > 3 && ((rr - 3) % 10 == 0 || $urandom_range(0, 7) == 0)));
      serial_in_sync = (rr == 3) ? (kind == K_FALSE) : 1'($urandom_range(0, 1));
      packet_done    = (kind != K_TMO) && (rr == d || rr == d + 1);
      framing_error  = (t == d + 3) ? (kind == K_FERR) : 1'($urandom_range(0, 1));
      if (kind == K_RST && t == r) begin
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
      end
      if (kind == K_RST && t == r + 1) begin
        #2 rst = 1'b0;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int kind, d, r;
    rst = 1'b1;
    start_bit_detected = 1'b0;
    serial_in_sync = 1'b1;
    shift_enable = 1'b0;
    packet_done = 1'b0;
    framing_error = 1'b0;
    merr[0] = 0;
    merr[1] = 0;
    for (int i = 0; i < 2; i++) begin
      prev_et[i] = 0; prev_busy[i] = 0; prev_err[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    #2 rst = 1'b0;
    mon_en = 1'b1;

    run_packet(K_GOOD,  94,      0,  1'b0);
    run_packet(K_FERR,  94,      0,  1'b0);
    run_packet(K_FALSE, 94,      0,  1'b0);
    run_packet(K_TMO,   0,       0,  1'b0);
    run_packet(K_GOOD,  TIMEOUT, 0,  1'b0);
    run_packet(K_RST,   94,      40, 1'b0);
    run_packet(K_GOOD,  94,      0,  1'b0);
    run_packet(K_GOOD,  94,      0,  1'b1);
    run_packet(K_FERR,  TIMEOUT, 0,  1'b1);

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6:  kind = K_GOOD;
        7, 8, 9, 10, 11, 12:  kind = K_FERR;
        13, 14, 15:           kind = K_FALSE;
        16, 17:               kind = K_TMO;
        default:              kind = K_RST;
      endcase
      d = int'($urandom_range(4, TIMEOUT));
      r = int'($urandom_range(4, d + 1));
      run_packet(kind, d, r, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 270; i++) begin
      run_packet(K_FERR, int'($urandom_range(4, 12)), 0, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    cmp("dut_events_left",   longint'(q0.size()), 0);
    cmp("nochk_events_left", longint'(q1.size()), 0);
    cmp("dut_err_saturated",   longint'(err0), 255);
    cmp("nochk_err_saturated", longint'(err1), 255);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
